// File: rtl/cpu_debug_cmd_sync_pkg.sv
// -----------------------------------------------------------------------------
// cpu_debug_pkg
// Shared definitions for the CPU JTAG debug slave, system-clock side:
//   - default IR/DR widths and the DR bit that selects action vs no-action
//   - channel index constants (value of the captured virtual IR)
//   - issue state machine encoding
//   - saturating counter helper
// -----------------------------------------------------------------------------
package cpu_debug_pkg;

    localparam int IR_W_DEF        = 2;
    localparam int DR_W_DEF        = 38;
    localparam int ACT_BIT_DEF     = 35;
    localparam int NUM_CH_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FIFO_DEPTH_DEF  = 4;

    // Channel index = captured virtual IR value
    localparam logic [IR_W_DEF-1:0] CH_OCIMEM    = 2'd0;
    localparam logic [IR_W_DEF-1:0] CH_TRACECTRL = 2'd1;
    localparam logic [IR_W_DEF-1:0] CH_BREAK     = 2'd2;
    localparam logic [IR_W_DEF-1:0] CH_RSVD      = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_t;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/cpu_debug_cmd_sync_if.sv
// -----------------------------------------------------------------------------
// cpu_debug_cmd_sync_if
// Bundles the TCK-side update/capture signals and the command issue handshake.
//   slave  : the command receiver (consumes ir_in/sr/vs_*/out_ready,
//            drives jdo and the per-channel strobes)
//   master : the environment (TCK shift logic + debug core)
// -----------------------------------------------------------------------------
import cpu_debug_pkg::*;

interface cpu_debug_cmd_sync_if #(
    parameter int IR_W   = IR_W_DEF,
    parameter int DR_W   = DR_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF
);
    logic [IR_W-1:0]   ir_in;
    logic [DR_W-1:0]   sr;
    logic              vs_uir;
    logic              vs_udr;
    logic              out_ready;
    logic [DR_W-1:0]   jdo;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;
    logic              ill_cmd;

    modport slave (
        input  ir_in, sr, vs_uir, vs_udr, out_ready,
        output jdo, take_action, take_no_action, ill_cmd
    );

    modport master (
        output ir_in, sr, vs_uir, vs_udr, out_ready,
        input  jdo, take_action, take_no_action, ill_cmd
    );
endinterface

// File: rtl/cpu_debug_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cpu_debug_cmd_fifo
// WIDTH x DEPTH synchronous FIFO, show-ahead read (rdata = head entry).
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored and the contents stay untouched. Pop while empty
// is ignored.
// Ports: clk, reset_n (async, active-low), push, pop, wdata, rdata,
//        full, empty, level (occupancy, 0..DEPTH).
// -----------------------------------------------------------------------------
module cpu_debug_cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == '0);
    assign do_pop_s  = pop & ~empty;
    // the pop frees a slot first, so a push to a full FIFO is fine then
    assign do_push_s = push & (~full | do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_debug_cmd_sync.sv
// -----------------------------------------------------------------------------
// cpu_debug_cmd_sync
// System-clock command receiver for the CPU JTAG debug slave.
//   - synchronizes vs_uir / vs_udr, detects their rising edges
//   - captures IR on uir rise, pushes {ir_q, sr} on udr rise
//   - issues one command per cycle while out_ready=1: registers jdo and
//     pulses take_action[ch], take_no_action[ch] or ill_cmd for one cycle
//   - counts commands dropped because the queue was full
// Ports: clk, reset_n (async, active-low), bus (slave modport: ir_in, sr,
//        vs_uir, vs_udr, out_ready, jdo, take_action, take_no_action,
//        ill_cmd), clr_overflow, fifo_level, overflow, drop_cnt.
// -----------------------------------------------------------------------------
module cpu_debug_cmd_sync
    import cpu_debug_pkg::*;
#(
    parameter int IR_W        = IR_W_DEF,
    parameter int DR_W        = DR_W_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    cpu_debug_cmd_sync_if.slave           bus,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);
    // synchronizer chains and edge detection
    logic [SYNC_STAGES-1:0] uir_sync_r;
    logic [SYNC_STAGES-1:0] udr_sync_r;
    logic [SYNC_STAGES-1:0] settle_r;
    logic                   uir_prev_r;
    logic                   udr_prev_r;
    logic                   uir_arm_r;
    logic                   udr_arm_r;
    logic                   uir_rise_r;
    logic                   udr_rise_r;
    logic                   settle_done_s;
    logic                   uir_lvl_s;
    logic                   udr_lvl_s;

    logic [IR_W-1:0]        ir_q_r;

    // queue
    logic [IR_W+DR_W-1:0]   head_s;
    logic [IR_W-1:0]        head_ir_s;
    logic [DR_W-1:0]        head_dr_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   issue_s;
    logic                   drop_s;

    // issue path
    issue_state_t           state_r;
    issue_state_t           state_next_s;
    logic [NUM_CH-1:0]      ta_s;
    logic [NUM_CH-1:0]      tna_s;
    logic                   legal_s;
    logic [DR_W-1:0]        jdo_r;
    logic [NUM_CH-1:0]      ta_r;
    logic [NUM_CH-1:0]      tna_r;
    logic                   ill_r;
    logic                   overflow_r;
    logic [7:0]             drop_cnt_r;

    assign settle_done_s = settle_r[SYNC_STAGES-1];
    assign uir_lvl_s     = uir_sync_r[SYNC_STAGES-1];
    assign udr_lvl_s     = udr_sync_r[SYNC_STAGES-1];

    // Synchronizers and rising-edge detectors. An edge is only honoured once
    // the chain has flushed after reset and the level has been seen low, so a
    // vs_udr held high across reset release is not mistaken for an update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_r <= '0;
            udr_sync_r <= '0;
            settle_r   <= '0;
            uir_prev_r <= 1'b0;
            udr_prev_r <= 1'b0;
            uir_arm_r  <= 1'b0;
            udr_arm_r  <= 1'b0;
            uir_rise_r <= 1'b0;
            udr_rise_r <= 1'b0;
        end else begin
            uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], bus.vs_uir};
            udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], bus.vs_udr};
            settle_r   <= {settle_r[SYNC_STAGES-2:0], 1'b1};
            uir_arm_r  <= uir_arm_r | (settle_done_s & ~uir_lvl_s);
            udr_arm_r  <= udr_arm_r | (settle_done_s & ~udr_lvl_s);
            uir_prev_r <= uir_lvl_s;
            udr_prev_r <= udr_lvl_s;
            uir_rise_r <= uir_lvl_s & ~uir_prev_r & uir_arm_r;
            udr_rise_r <= udr_lvl_s & ~udr_prev_r & udr_arm_r;
        end
    end

    // IR capture; a push in the same cycle still sees the previous ir_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q_r <= '0;
        end else if (uir_rise_r) begin
            ir_q_r <= bus.ir_in;
        end else begin
            ir_q_r <= ir_q_r;
        end
    end

    assign issue_s = ~empty_s & bus.out_ready;
    assign drop_s  = udr_rise_r & full_s & ~issue_s;

    cpu_debug_cmd_fifo #(
        .WIDTH (IR_W + DR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (udr_rise_r),
        .pop     (issue_s),
        .wdata   ({ir_q_r, bus.sr}),
        .rdata   (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    assign head_ir_s = head_s[IR_W+DR_W-1:DR_W];
    assign head_dr_s = head_s[DR_W-1:0];

    // Issue state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Issue next-state: stay in ISSUE while a command can go out every cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = issue_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_next_s = issue_s ? ST_ISSUE : ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Decode head entry into one channel strobe, or illegal if IR >= NUM_CH
    always_comb begin
        ta_s    = '0;
        tna_s   = '0;
        legal_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ta_s[i]  = (head_ir_s == IR_W'(i)) &  head_dr_s[ACT_BIT];
            tna_s[i] = (head_ir_s == IR_W'(i)) & ~head_dr_s[ACT_BIT];
            legal_s  = legal_s | (head_ir_s == IR_W'(i));
        end
    end

    // Registered issue outputs; jdo holds between issues
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_r <= '0;
            ta_r  <= '0;
            tna_r <= '0;
            ill_r <= 1'b0;
        end else if (issue_s) begin
            jdo_r <= head_dr_s;
            ta_r  <= ta_s;
            tna_r <= tna_s;
            ill_r <= ~legal_s;
        end else begin
            jdo_r <= jdo_r;
            ta_r  <= '0;
            tna_r <= '0;
            ill_r <= 1'b0;
        end
    end

    // Drop tracking; a drop in the clear cycle wins and restarts the count at 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= clr_overflow ? 8'd1 : sat_inc8(drop_cnt_r);
        end else if (clr_overflow) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.jdo            = jdo_r;
    assign bus.take_action    = ta_r;
    assign bus.take_no_action = tna_r;
    assign bus.ill_cmd        = ill_r;
    assign overflow           = overflow_r;
    assign drop_cnt           = drop_cnt_r;

endmodule

// File: doc/cpu_debug_cmd_sync.md
# cpu_debug_cmd_sync

System-clock-side command receiver for the CPU JTAG debug slave, and the parametrised successor to the fixed 2-bit-IR / 38-bit-DR sysclk stage.
- Brings the virtual-JTAG update strobes into `clk`, captures IR and DR contents, and queues commands in a small FIFO.
- Issues one-cycle `take_action` / `take_no_action` strobes per channel under a ready handshake, so back-to-back JTAG commands are not lost while the debug core is busy.
- Sits between the TCK-domain shift logic and the OCI break, memory and trace-control logic.

## Interface
- `IR_W`, 2: virtual IR width; channel index = captured IR.
- `DR_W`, 38: data register (`sr`/`jdo`) width.
- `NUM_CH`, 4: number of action channels; requires NUM_CH ≤ 2^IR_W.
- `ACT_BIT`, 35: DR bit selecting action (1) vs no-action (0).
- `SYNC_STAGES`, 2: synchronizer depth for `vs_uir`/`vs_udr`; minimum 2.
- `FIFO_DEPTH`, 4: command queue entries; power of two, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `ir_in` in IR_W: virtual IR from the TCK domain; stable while `vs_uir` is high.
- `sr` in DR_W: shifted DR from the TCK domain; stable from the `vs_udr` rise until the next capture-DR.
- `vs_uir` in 1: update-IR level from the TCK domain; asynchronous.
- `vs_udr` in 1: update-DR level from the TCK domain; asynchronous.
- `out_ready` in 1: consumer can accept a command this cycle.
- `clr_overflow` in 1: clears `overflow` and `drop_cnt`.
- `jdo` out DR_W: DR of the command currently being issued; held until the next issue.
- `take_action` out NUM_CH: one-cycle strobe, channel = IR, `jdo[ACT_BIT]`=1.
- `take_no_action` out NUM_CH: one-cycle strobe, `jdo[ACT_BIT]`=0.
- `ill_cmd` out 1: one-cycle pulse; issued IR ≥ NUM_CH.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a command was dropped.
- `drop_cnt` out 8: count of dropped commands, saturating at 255.

## Operation
- **Synchronizers.** `vs_uir` and `vs_udr` each pass through SYNC_STAGES flops, then a rising-edge detect register.
- **IR capture.** On a synchronized `vs_uir` rise, capture `ir_in` into `ir_q`.
- **DR capture and push.** On a synchronized `vs_udr` rise, sample `sr` and push {`ir_q`, `sr`} into the FIFO.
- **Issue.** An issue happens when the FIFO is non-empty and `out_ready`=1 in the same cycle. On issue:
  - pop the head entry and register `jdo` ← DR;
  - pulse exactly one of `take_action[ch]`, `take_no_action[ch]` or `ill_cmd` in the next cycle.
- **No issue.** While not issuing, all strobes are 0 and `jdo` holds its last value.
- **Full FIFO.** A push to a full FIFO is dropped: set `overflow`, increment `drop_cnt` (saturating), leave contents untouched.
- **Push and pop in the same cycle.** Both occur; this is legal even when full, because the pop frees the slot first. `fifo_level` is unchanged.
- **uir and udr edges in the same cycle.** The push uses the `ir_q` value from before this cycle's IR capture.
- **`clr_overflow` vs drop.** If `clr_overflow` and a drop occur in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- **Issue state machine.** IDLE → ISSUE when the FIFO is non-empty and `out_ready`=1; ISSUE → ISSUE while that condition still holds, giving one issue per cycle; ISSUE → IDLE otherwise.
- **Reset.** Asynchronous `reset_n` low, including mid-queue:
  - FIFO emptied, state → IDLE;
  - `jdo`=0, all strobes 0, `ill_cmd`=0, `fifo_level`=0, `overflow`=0, `drop_cnt`=0;
  - `ir_q`=0, synchronizers and edge registers = 0. A `vs_udr` held high through reset release causes no push.

## Timing
- Latency from a `vs_udr` rise to the strobe, with FIFO empty and `out_ready`=1: SYNC_STAGES+3 `clk` cycles, plus up to one cycle of metastability uncertainty. The breakdown is:
  - SYNC_STAGES cycles of synchronizer;
  - 1 cycle edge detect;
  - 1 cycle FIFO write;
  - 1 cycle issue register.
- Throughput: one command issued per cycle.
- Each JTAG update must remain high for at least SYNC_STAGES+1 `clk` periods, and low for the same between updates. This is met by TCK ≤ clk/4.

## Structure
- Shared package `cpu_debug_pkg`:
  - IR/DR default widths;
  - `ACT_BIT` default;
  - the channel index constants CH_OCIMEM=0, CH_TRACECTRL=1, CH_BREAK=2, CH_RSVD=3.
- One sub-module, `cpu_debug_cmd_fifo`: a parametrised width×depth synchronous FIFO with full/empty/level outputs.
- Synchronizers are inline.

## Test plan
- **Single command.** `ir_in`=2 with a uir pulse, then `sr[35]`=1 with a udr pulse, `out_ready`=1 → `take_action[2]`=1 for exactly one cycle, SYNC_STAGES+3(±1) cycles after the udr rise; `jdo`=`sr`.
- **No-action and illegal.** `sr[35]`=0 with IR=0 → `take_no_action[0]` pulse. With NUM_CH=3 and IR=3 → `ill_cmd` pulse and no channel strobe.
- **Backpressure.** `out_ready`=0; push 4 commands → `fifo_level`=4. Push a 5th → `overflow`=1, `drop_cnt`=1. Raise `out_ready` → 4 strobes on consecutive cycles, in order, with matching `jdo` values.
- **Full FIFO, simultaneous push and pop.** With FIFO full and `out_ready`=1 in the push cycle → no drop, `fifo_level` stays 4.
- **Clear and saturation.** Issue 300 drops → `drop_cnt`=255. `clr_overflow` → 0. `clr_overflow` in the same cycle as a drop → `drop_cnt`=1, `overflow`=1.
- **Reset mid-queue.** Assert `reset_n` low with 3 entries queued and `vs_udr` held high → all outputs reset immediately. After release: no strobe and `fifo_level`=0 until a fresh udr edge arrives.
